// File: rtl/cmd_rcv_pkg.sv
// rtl/cmd_rcv_pkg.sv - shared constants, command codes and byte FSM states for cmd_rcv
package cmd_rcv_pkg;

    localparam int FRM_BYTES = 3;

    typedef enum logic [1:0] {
        STRT_CMD  = 2'b00,
        READ_EEP  = 2'b01,
        WRITE_EEP = 2'b10,
        NEW_XSET  = 2'b11
    } cmd_t;

    localparam int CMD_HI  = 19;
    localparam int CMD_LO  = 18;
    localparam int ADDR_HI = 17;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 13;
    localparam int DATA_LO = 0;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

    function automatic cmd_t frm_cmd(input logic [23:0] frm);
        return cmd_t'(frm[CMD_HI:CMD_LO]);
    endfunction

endpackage

// File: rtl/cmd_rcv_uart_rx_byte.sv
// rtl/cmd_rcv_uart_rx_byte.sv - 8N1 byte deserializer with mid-bit sampling and glitch reject
module uart_rx_byte
    import cmd_rcv_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sync,
    output logic       byte_vld,
    output logic       byte_err,
    output logic [7:0] rx_byte,
    output logic       idle
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BAUD_DIV - 1);

    rx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    // Resets low so a line already held low after reset never looks like a falling edge.
    logic          rx_prev;

    assign idle = (state == RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_byte  <= '0;
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            rx_prev  <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            rx_prev  <= rx_sync;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        baud_cnt <= '0;
                        state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_cnt == HALF_M1) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BIT_M1) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_sync, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BIT_M1) begin
                        baud_cnt <= '0;
                        if (rx_sync) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            byte_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_rcv.sv
// rtl/cmd_rcv.sv - UART command-frame receiver producing cfg_data with frm_rdy/clr_rdy handshake
module cmd_rcv
    import cmd_rcv_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int TO_CYC   = 8680
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_rdy,
    output logic [23:0] cfg_data,
    output logic        frm_rdy,
    output logic        frm_err,
    output logic        ovr_err,
    output logic        busy
);

    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_M1     = TW'(TO_CYC - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(FRM_BYTES - 1);

    logic          rx_s1, rx_s2;
    logic [1:0]    fill;
    logic          rx_sync;
    logic          byte_vld, byte_err, rx_idle;
    logic [7:0]    rx_byte;
    logic [1:0]    byte_cnt;
    logic [15:0]   shadow;
    logic [TW-1:0] to_cnt;

    // Until both sync stages hold real pin samples the line is presented as low,
    // so the first confirmed high must be seen before any falling edge counts.
    assign rx_sync = rx_s2 & fill[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            fill  <= 2'b00;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            fill  <= {fill[0], 1'b1};
        end
    end

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_sync  (rx_sync),
        .byte_vld (byte_vld),
        .byte_err (byte_err),
        .rx_byte  (rx_byte),
        .idle     (rx_idle)
    );

    assign busy = !rx_idle || (byte_cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_data <= '0;
            frm_rdy  <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
            byte_cnt <= '0;
            shadow   <= '0;
            to_cnt   <= '0;
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;

            if (!rx_idle || byte_cnt == 2'd0) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_M1) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (byte_vld && byte_cnt == LAST_BYTE) begin
                // A concurrent clr_rdy frees the holding slot, so the new frame is accepted.
                if (!frm_rdy || clr_rdy) begin
                    cfg_data <= {shadow, rx_byte};
                    frm_rdy  <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end else if (clr_rdy) begin
                frm_rdy <= 1'b0;
            end

            if (byte_err) begin
                byte_cnt <= '0;
                frm_err  <= 1'b1;
            end else if (byte_vld) begin
                case (byte_cnt)
                    2'd0:    shadow[15:8] <= rx_byte;
                    2'd1:    shadow[7:0]  <= rx_byte;
                    default: ;
                endcase
                byte_cnt <= (byte_cnt == LAST_BYTE) ? 2'd0 : byte_cnt + 2'd1;
            end else if (rx_idle && byte_cnt != 2'd0 && to_cnt == TO_M1) begin
                byte_cnt <= '0;
                frm_err  <= 1'b1;
            end
        end
    end

endmodule
